ultrasonic_ranger_mc: RTL and testbench

- Parametrised multi-channel HC-SR04-style ultrasonic ranging engine, successor to the single-channel trigger/echo counter.
- Fires each of N_CH sensors in turn, one per time slot, on a 1 us timebase derived from clk.
- Measures each echo pulse width, converts it to centimetres and publishes one distance register per channel, with a valid strobe and a timeout flag.
- Sits between the sensor pins and the display/control logic.

---
 rtl/ultrasonic_ranger_mc.sv | 204 ++++++++++++++++++++
 tb/tb_ultrasonic_ranger_mc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin multi-channel ultrasonic ranger: fires one sensor per fixed-length slot on a
// 1 us timebase, times the echo and publishes a per-channel distance in cm with valid/timeout.
module ultrasonic_ranger_mc #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DIST_W      = 16,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned SLOT_US     = 60_000,
  parameter int unsigned RISE_TO_US  = 30_000,
  parameter int unsigned MAX_ECHO_US = 25_000,
  parameter int unsigned US_PER_CM   = 58,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N_CH-1:0]          echo,
  output logic [N_CH-1:0]          trigger,
  output logic [N_CH*DIST_W-1:0]   distance,
  output logic [N_CH-1:0]          valid,
  output logic [N_CH-1:0]          timeout,
  output logic                     busy,
  output logic [CH_W-1:0]          cur_ch
);

  localparam int unsigned PRE    = CLK_HZ / 1_000_000;
  localparam int unsigned PRE_W  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int unsigned SLOT_W = $clog2(SLOT_US + 1);
  localparam int unsigned WAIT_W = $clog2(RISE_TO_US + 1);
  localparam int unsigned ECHO_W = $clog2(MAX_ECHO_US + 1);
  localparam int unsigned SUB_W  = $clog2(US_PER_CM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GAP
  } state_t;

  state_t              state;
  logic [PRE_W-1:0]    pre_cnt;
  logic                us_tick;
  logic [SLOT_W-1:0]   slot_us;
  logic [SLOT_W-1:0]   slot_inc;
  logic [WAIT_W-1:0]   wait_us;
  logic [WAIT_W-1:0]   wait_inc;
  logic [ECHO_W-1:0]   echo_us;
  logic [ECHO_W-1:0]   echo_inc;
  logic [SUB_W-1:0]    sub_cnt;
  logic [SUB_W-1:0]    sub_inc;
  logic [DIST_W-1:0]   cm;
  logic [N_CH-1:0]     echo_s1;
  logic [N_CH-1:0]     echo_s2;
  logic [N_CH-1:0]     echo_d;
  logic                echo_cur;
  logic                echo_rise;
  logic                echo_fall;
  logic                slot_end;
  logic                advance;
  logic [CH_W-1:0]     next_ch;

  // Prescaler is held at zero while idle so every slot starts on a fresh us boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (state == S_IDLE || pre_cnt == PRE_W'(PRE - 1)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  assign us_tick = (state != S_IDLE) && (pre_cnt == PRE_W'(PRE - 1));

  // Two-flop synchroniser plus one delay stage for edge detection on every channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_d  <= '0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  assign echo_cur  = echo_s2[cur_ch];
  assign echo_rise = echo_cur & ~echo_d[cur_ch];
  assign echo_fall = ~echo_cur & echo_d[cur_ch];

  assign slot_inc = slot_us + SLOT_W'(1);
  assign wait_inc = wait_us + WAIT_W'(1);
  assign echo_inc = echo_us + ECHO_W'(1);
  assign sub_inc  = sub_cnt + SUB_W'(1);
  assign slot_end = us_tick && (slot_inc == SLOT_W'(SLOT_US));
  assign advance  = slot_end && (state inside {S_WAIT_RISE, S_MEASURE, S_GAP});
  assign next_ch  = (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + CH_W'(1);

  // Ranging FSM; the slot boundary overrides whatever the measurement was doing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      trigger  <= '0;
      distance <= '0;
      valid    <= '0;
      timeout  <= '0;
      busy     <= 1'b0;
      cur_ch   <= '0;
      slot_us  <= '0;
      wait_us  <= '0;
      echo_us  <= '0;
      sub_cnt  <= '0;
      cm       <= '0;
    end else begin
      valid <= '0;
      if (state != S_IDLE && us_tick) begin
        slot_us <= slot_inc;
      end

      case (state)
        S_IDLE: begin
          if (enable) begin
            state   <= S_TRIG;
            busy    <= 1'b1;
            trigger <= N_CH'(1) << cur_ch;
            slot_us <= '0;
          end
        end
        S_TRIG: begin
          if (us_tick && slot_inc == SLOT_W'(TRIG_US)) begin
            trigger <= '0;
            wait_us <= '0;
            state   <= S_WAIT_RISE;
          end
        end
        S_WAIT_RISE: begin
          if (!slot_end) begin
            if (echo_rise) begin
              // A tick coinciding with the detected rise already belongs to the echo.
              state   <= S_MEASURE;
              echo_us <= ECHO_W'(us_tick);
              sub_cnt <= (us_tick && US_PER_CM > 1) ? SUB_W'(1) : '0;
              cm      <= (us_tick && US_PER_CM == 1) ? DIST_W'(1) : '0;
            end else if (us_tick) begin
              wait_us <= wait_inc;
              if (wait_inc == WAIT_W'(RISE_TO_US)) begin
                timeout[cur_ch] <= 1'b1;
                state           <= S_GAP;
              end
            end
          end
        end
        S_MEASURE: begin
          if (!slot_end) begin
            if (echo_fall) begin
              distance[cur_ch*DIST_W +: DIST_W] <= cm;
              timeout[cur_ch] <= 1'b0;
              valid[cur_ch]   <= 1'b1;
              state           <= S_GAP;
            end else if (us_tick && echo_cur) begin
              echo_us <= echo_inc;
              if (sub_inc == SUB_W'(US_PER_CM)) begin
                sub_cnt <= '0;
                if (cm != '1) begin
                  cm <= cm + DIST_W'(1);
                end
              end else begin
                sub_cnt <= sub_inc;
              end
              if (echo_inc == ECHO_W'(MAX_ECHO_US)) begin
                timeout[cur_ch] <= 1'b1;
                state           <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (advance) begin
        if (state != S_GAP) begin
          timeout[cur_ch] <= 1'b1;
        end
        cur_ch  <= next_ch;
        slot_us <= '0;
        if (enable) begin
          state   <= S_TRIG;
          trigger <= N_CH'(1) << next_ch;
        end else begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Bench for ultrasonic_ranger_mc: slot-level timing model compared every cycle, plus literal spot checks.
module tb_ultrasonic_ranger_mc;

  localparam int NSL = 9;
  localparam int S0  = 11;
  localparam int SLOT_CLK = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  echo = '0;
  logic [1:0]  trigger;
  logic [31:0] distance;
  logic [1:0]  valid;
  logic [1:0]  timeout;
  logic        busy;
  logic [0:0]  cur_ch;

  int checks = 0;
  int errors = 0;

  ultrasonic_ranger_mc #(
    .CLK_HZ(2_000_000), .N_CH(2), .DIST_W(16), .TRIG_US(10), .SLOT_US(2000),
    .RISE_TO_US(500), .MAX_ECHO_US(1500), .US_PER_CM(58)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trigger(trigger),
    .distance(distance), .valid(valid), .timeout(timeout), .busy(busy), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slot plan: channel, echo rise (us after trigger fall, -1 = none), echo high time (us).
  int sl_ch[NSL]   = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int sl_rise[NSL] = '{100, 50, -1, 20, 30, -1, 100, 10, -1};
  int sl_high[NSL] = '{580, 1160, 0, 300, 290, 0, 1800, 600, 0};
  int sl_s[NSL], rr[NSL], ff[NSL], ev_cyc[NSL], ev_good[NSL], ev_dist[NSL];

  initial begin
    int          exp_dist[2];
    logic [1:0]  exp_to, exp_valid, exp_trig, echo_v, prev_trig;
    logic        exp_busy, exp_ch, model_on;
    int          trig0_len, t0_first, t1_first, t1_last, v0_cnt;
    int          s8, last_cyc;

    for (int i = 0; i < NSL; i++) begin
      sl_s[i] = (i < 8) ? S0 + SLOT_CLK * i : S0 + 32021;
      ev_cyc[i] = -1; ev_good[i] = 0; ev_dist[i] = 0; rr[i] = -1; ff[i] = -1;
      if (sl_rise[i] < 0) begin
        if (i < 8) ev_cyc[i] = sl_s[i] + 20 + 2 * 500;
      end else begin
        rr[i] = sl_s[i] + 20 + 2 * sl_rise[i];
        ff[i] = rr[i] + 2 * sl_high[i];
        if (sl_high[i] >= 1500) begin
          ev_cyc[i] = rr[i] + 2 + 2 * 1500;
        end else begin
          ev_cyc[i]  = ff[i] + 3;
          ev_good[i] = 1;
          ev_dist[i] = sl_high[i] / 58;
        end
      end
    end
    s8 = sl_s[8];
    last_cyc = s8 + 15;
    exp_dist = '{0, 0};
    exp_to = '0;
    model_on = 1'b1;
    trig0_len = 0; t0_first = -1; t1_first = -1; t1_last = -1; v0_cnt = 0;
    prev_trig = '0;

    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(posedge clk);
      #1;
      exp_valid = '0;
      for (int i = 0; i < NSL; i++) begin
        if (cyc == ev_cyc[i]) begin
          if (ev_good[i] == 1) begin
            exp_dist[sl_ch[i]]  = ev_dist[i];
            exp_to[sl_ch[i]]    = 1'b0;
            exp_valid[sl_ch[i]] = 1'b1;
          end else begin
            exp_to[sl_ch[i]] = 1'b1;
          end
        end
      end
      exp_trig = '0; exp_busy = 1'b0; exp_ch = 1'b0;
      for (int i = 0; i < NSL; i++) begin
        if (cyc >= sl_s[i] + SLOT_CLK) exp_ch = 1'((sl_ch[i] + 1) % 2);
      end
      for (int i = 0; i < NSL; i++) begin
        if (cyc >= sl_s[i] && cyc < sl_s[i] + SLOT_CLK) begin
          exp_busy = 1'b1;
          exp_ch   = 1'(sl_ch[i]);
          if (cyc < sl_s[i] + 20) exp_trig[sl_ch[i]] = 1'b1;
        end
      end
      if (model_on) begin
        checks++;
        if ({trigger, valid, distance, timeout, busy, cur_ch} !==
            {exp_trig, exp_valid, 16'(exp_dist[1]), 16'(exp_dist[0]), exp_to, exp_busy, exp_ch}) begin
          errors++;
          $display("FAIL cycle_outputs @%0d: got trig=%b valid=%b dist=%h to=%b busy=%b ch=%b expected trig=%b valid=%b dist=%h%h to=%b busy=%b ch=%b",
                   cyc, trigger, valid, distance, timeout, busy, cur_ch,
                   exp_trig, exp_valid, 16'(exp_dist[1]), 16'(exp_dist[0]), exp_to, exp_busy, exp_ch);
        end
      end

      if (cyc < S0 + SLOT_CLK && trigger[0]) trig0_len++;
      if (trigger[0] && !prev_trig[0] && t0_first < 0) t0_first = cyc;
      if (trigger[1] && !prev_trig[1]) begin
        if (t1_first < 0) t1_first = cyc;
        t1_last = cyc;
      end
      if (valid[0]) v0_cnt++;
      prev_trig = trigger;

      if (cyc == 2) chk("reset_state", 64'({trigger, valid, distance, timeout, busy, cur_ch}), 64'd0);
      if (cyc == S0 + 1500) begin
        chk("basic_dist0", 64'(distance[15:0]), 64'd10);
        chk("basic_timeout0", 64'(timeout[0]), 64'd0);
        chk("basic_valid0_count", 64'(v0_cnt), 64'd1);
        chk("trig0_width", 64'(trig0_len), 64'd20);
      end
      if (cyc == S0 + 7000) begin
        chk("rr_dist1", 64'(distance[31:16]), 64'd20);
        chk("rr_trig_spacing", 64'(t1_first - t0_first), 64'd4000);
      end
      if (cyc == S0 + 9019) chk("noecho_to0_before", 64'(timeout[0]), 64'd0);
      if (cyc == S0 + 9020) chk("noecho_to0_at", 64'(timeout[0]), 64'd1);
      if (cyc == S0 + 11000) begin
        chk("noecho_dist0_kept", 64'(distance[15:0]), 64'd10);
        chk("noecho_no_valid0", 64'(v0_cnt), 64'd1);
      end
      if (cyc == S0 + 19000) begin
        chk("followup_dist0", 64'(distance[15:0]), 64'd5);
        chk("followup_to0_clr", 64'(timeout[0]), 64'd0);
      end
      if (cyc == S0 + 27221) chk("long_to0_before", 64'(timeout[0]), 64'd0);
      if (cyc == S0 + 27222) chk("long_to0_at", 64'(timeout[0]), 64'd1);
      if (cyc == S0 + 28001) begin
        chk("long_next_trig_on_boundary", 64'(t1_last - t0_first), 64'd28000);
        chk("long_trig_ch1", 64'(trigger), 64'd2);
      end
      if (cyc == S0 + 31000) begin
        chk("en_drop_dist1", 64'(distance[31:16]), 64'd10);
        chk("en_drop_to1", 64'(timeout[1]), 64'd0);
      end
      if (cyc == S0 + 32005) begin
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_cur_ch", 64'(cur_ch), 64'd0);
        chk("idle_trigger", 64'(trigger), 64'd0);
      end
      if (cyc == s8 + 12) begin
        chk("post_reset_busy", 64'(busy), 64'd0);
        chk("post_reset_dist", 64'(distance), 64'd0);
      end

      if (cyc == 3) rst = 1'b1;
      if (cyc == 10) enable = 1'b1;
      if (cyc == S0 + 28600) enable = 1'b0;
      if (cyc == s8 - 1) enable = 1'b1;
      if (cyc == s8 + 8) rst = 1'b1;
      echo_v = '0;
      for (int i = 0; i < NSL; i++) begin
        if (rr[i] >= 0 && cyc >= rr[i] && cyc < ff[i]) echo_v[sl_ch[i]] = 1'b1;
      end
      echo = echo_v;

      if (cyc == s8 + 5) begin
        enable = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_on = 1'b0;
        chk("async_rst_trigger", 64'(trigger), 64'd0);
        chk("async_rst_distance", 64'(distance), 64'd0);
        chk("async_rst_valid", 64'(valid), 64'd0);
        chk("async_rst_timeout", 64'(timeout), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_cur_ch", 64'(cur_ch), 64'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
